seq_separator_fifo: RTL and testbench
=====================================

SEQ_SEPARATOR_FIFO -- requirements
Module: seq_separator_fifo

Interface
REQ-001 Parameter SYMS, default 5: symbols per encoded sequence, each 2 bits; SEQ_W = 2*SYMS, legal SYMS >= 1.
REQ-002 Parameter DEPTH, default 4: output queue entries, power of two, DEPTH >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enc_seq  input  SEQ_W  encoded sequence; symbol pairs MSB-first: 00 dot, 01 dash, 10 space, 11 empty.
REQ-006 space_endseqbar  input  1  command type: 1 = Space, 0 = EndSeq.
REQ-007 cmd_valid  input  1  command present on enc_seq/space_endseqbar.
REQ-008 cmd_ready  output  1  block can accept a command this cycle.
REQ-009 out_seq  output  SEQ_W  head-of-queue sequence.
REQ-010 out_valid  output  1  out_seq holds a valid queued sequence.
REQ-011 out_ready  input  1  consumer takes out_seq when out_valid.
REQ-012 count  output  clog2(DEPTH+1)  number of occupied queue entries.
REQ-013 drop_empty  output  1  one-cycle pulse: an empty EndSeq command was accepted and discarded.

Function
REQ-014 Command accepted on a rising edge with cmd_valid && cmd_ready; output popped on a rising edge with out_valid && out_ready.
REQ-015 Sequence is empty iff enc_seq[SEQ_W-1:SEQ_W-2] == 2'b11; SPACE word = 2'b10 followed by SEQ_W-2 ones; EMPTY word = all ones.
REQ-016 EndSeq, non-empty: push enc_seq (one entry).
REQ-017 EndSeq, empty: push nothing; drop_empty = 1 the following cycle.
REQ-018 Space, empty: push SPACE word (one entry).
REQ-019 Space, non-empty: push enc_seq on the accept edge, then push SPACE word on a later edge; order in queue is always sequence then SPACE, never interleaved with another command.
REQ-020 FSM states: IDLE, SPACE_PEND. IDLE -> SPACE_PEND on acceptance of a Space/non-empty command; SPACE_PEND -> IDLE on the edge the SPACE word is pushed; all other cases hold.
REQ-021 SPACE_PEND pushes SPACE word on the first edge where count < DEPTH or a pop occurs in the same cycle; it stalls indefinitely otherwise.
REQ-022 cmd_ready = !rst && state == IDLE && (count < DEPTH || (out_valid && out_ready)); combinational, independent of cmd_valid.
REQ-023 Simultaneous push and pop: count unchanged; pushing into the slot freed by a pop in the same cycle is legal when full.
REQ-024 out_valid = (count != 0); out_seq = head entry when out_valid, EMPTY word otherwise.
REQ-025 Latency: entry pushed on edge k is visible with out_valid on cycle k+1 when queue was empty (no fall-through in the push cycle).
REQ-026 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-027 Pop with out_valid = 0 is ignored; command with cmd_ready = 0 is ignored and not stored.

Reset
REQ-028 On a clock edge with rst = 1: state IDLE, pointers 0, count 0, drop_empty 0; thereafter out_valid 0 and out_seq EMPTY word.
REQ-029 rst overrides all same-cycle pushes/pops; a pending SPACE word (SPACE_PEND) is discarded, not delivered.
REQ-030 cmd_ready = 0 while rst = 1; 1 in the first cycle after reset is released.

Verification (SYMS=5, DEPTH=4)
REQ-031 EndSeq enc_seq=10'b0001111111, out_ready=1 -> next cycle out_valid=1, out_seq=10'b0001111111, count=1; then empty.
REQ-032 Space enc_seq=10'b0100111111, out_ready=0 -> out_seq 10'b0100111111 then after pop 10'b1011111111; count 1 then 2; cmd_ready 0 during SPACE_PEND cycle.
REQ-033 Space enc_seq=10'b1111111111 -> single entry 10'b1011111111; EndSeq enc_seq=10'b1111111111 -> no entry, drop_empty pulse, count unchanged.
REQ-034 Fill to count=3, then Space/non-empty with out_ready=0 -> sequence pushed, count=4, SPACE_PEND stalls; one pop -> SPACE pushed same edge, count stays 4, state IDLE.
REQ-035 Full queue, cmd_valid and out_ready both 1 -> push and pop same edge, count stays 4, FIFO order preserved across pointer wrap over 10+ entries.
REQ-036 rst asserted during SPACE_PEND -> next cycle count=0, out_valid=0, out_seq all ones, no SPACE word emitted later.

Source files
------------

// File: rtl/seq_separator_fifo_if.sv
// seq_separator_fifo_if
// Bundles the command side and the queue-output side of seq_separator_fifo.
//   enc_seq          encoded sequence, 2-bit symbols MSB-first
//   space_endseqbar  command type: 1 = Space, 0 = EndSeq
//   cmd_valid        command present
//   cmd_ready        block can accept a command this cycle
//   out_seq          head-of-queue sequence (all ones when the queue is empty)
//   out_valid        out_seq holds a queued sequence
//   out_ready        consumer takes out_seq
//   count            occupied queue entries
//   drop_empty       one-cycle pulse when an empty EndSeq is discarded
// master = producer/consumer side, slave = the FIFO block.
interface seq_separator_fifo_if #(
  parameter int SYMS  = 5,
  parameter int DEPTH = 4
);
  localparam int seqW = 2 * SYMS;
  localparam int cntW = $clog2(DEPTH + 1);

  logic [seqW-1:0] enc_seq;
  logic            space_endseqbar;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [seqW-1:0] out_seq;
  logic            out_valid;
  logic            out_ready;
  logic [cntW-1:0] count;
  logic            drop_empty;

  modport master (
    output enc_seq, space_endseqbar, cmd_valid, out_ready,
    input  cmd_ready, out_seq, out_valid, count, drop_empty
  );

  modport slave (
    input  enc_seq, space_endseqbar, cmd_valid, out_ready,
    output cmd_ready, out_seq, out_valid, count, drop_empty
  );
endinterface

// File: rtl/seq_separator_fifo.sv
// seq_separator_fifo
// Turns Space/EndSeq commands carrying an encoded symbol sequence into a
// queue of sequence words. A Space after a non-empty sequence queues the
// sequence followed by a SPACE word (two pushes, the second one possibly
// stalled by a full queue); an empty EndSeq is dropped and flagged.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  seq_separator_fifo_if.slave (command in, queue out, status)
module seq_separator_fifo #(
  parameter int SYMS  = 5,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_separator_fifo_if.slave   bus
);
  localparam int seqW = 2 * SYMS;
  localparam int cntW = $clog2(DEPTH + 1);
  localparam int ptrW = $clog2(DEPTH);

  localparam logic [seqW-1:0] emptyWord = '1;
  // SPACE word: symbol 10 at the top followed by empty symbols.
  localparam logic [seqW-1:0] spaceWord = ~(seqW'(1) << (seqW - 2));
  localparam logic [cntW-1:0] depthCount = cntW'(DEPTH);

  typedef enum logic {IDLE, SPACE_PEND} stateType;

  stateType        state, stateNext;
  logic [seqW-1:0] mem [DEPTH];
  logic [ptrW-1:0] wrPtr, rdPtr;
  logic [cntW-1:0] count;
  logic            dropEmpty;

  logic            outValid;
  logic            popFire;
  logic            cmdReady;
  logic            accept;
  logic            isEmptySeq;
  logic            pushEn;
  logic [seqW-1:0] pushData;
  logic            dropNext;
  logic            notFull;

  assign isEmptySeq = (bus.enc_seq[seqW-1:seqW-2] == 2'b11);
  assign outValid   = (count != '0);
  assign popFire    = outValid && bus.out_ready;
  assign notFull    = (count < depthCount);
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign cmdReady   = !rst && (state == IDLE) && (notFull || popFire);
  assign accept     = bus.cmd_valid && cmdReady;

  assign bus.cmd_ready  = cmdReady;
  assign bus.out_valid  = outValid;
  assign bus.out_seq    = outValid ? mem[rdPtr] : emptyWord;
  assign bus.count      = count;
  assign bus.drop_empty = dropEmpty;

  // Next-state and push decision. In IDLE an accepted command pushes at
  // most one word; a Space with a real sequence parks in SPACE_PEND so the
  // SPACE word follows the sequence before any other command is taken.
  always_comb begin
    stateNext = state;
    pushEn    = 1'b0;
    pushData  = bus.enc_seq;
    dropNext  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.space_endseqbar) begin
            pushEn = 1'b1;
            if (isEmptySeq) begin
              pushData = spaceWord;
            end else begin
              stateNext = SPACE_PEND;
            end
          end else if (isEmptySeq) begin
            dropNext = 1'b1;
          end else begin
            pushEn = 1'b1;
          end
        end
      end
      SPACE_PEND: begin
        if (!rst && (notFull || popFire)) begin
          pushEn    = 1'b1;
          pushData  = spaceWord;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Control registers: FSM, pointers, occupancy and the drop pulse.
  // Reset wins over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      dropEmpty <= 1'b0;
    end else begin
      state     <= stateNext;
      dropEmpty <= dropNext;
      if (pushEn) begin
        wrPtr <= wrPtr + ptrW'(1);
      end
      if (popFire) begin
        rdPtr <= rdPtr + ptrW'(1);
      end
      case ({pushEn, popFire})
        2'b10:   count <= count + cntW'(1);
        2'b01:   count <= count - cntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (pushEn && !rst) begin
      mem[wrPtr] <= pushData;
    end
  end
endmodule

// File: tb/tb_seq_separator_fifo.sv
// tb_seq_separator_fifo
// Directed self-checking bench for seq_separator_fifo (SYMS=5, DEPTH=4).
// Inputs change 1 time unit after the rising edge, outputs are compared
// one more unit later, well away from the next edge.
module tb_seq_separator_fifo;
  logic clk;
  logic rst;
  int   checks;
  int   passes;

  seq_separator_fifo_if #(.SYMS(5), .DEPTH(4)) bus ();

  seq_separator_fifo #(.SYMS(5), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one set of command/consumer inputs and let combinational logic settle.
  task automatic applyStimulus(input logic v, input logic s,
                               input logic [9:0] seq, input logic ordy);
    bus.cmd_valid       = v;
    bus.space_endseqbar = s;
    bus.enc_seq         = seq;
    bus.out_ready       = ordy;
    #1;
  endtask

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      passes++;
    end
  endtask

  logic [9:0] expq[$];
  logic [9:0] drainList[4];
  logic [9:0] val;

  initial begin
    checks = 0;
    passes = 0;
    rst    = 1'b1;
    bus.cmd_valid       = 1'b0;
    bus.space_endseqbar = 1'b0;
    bus.enc_seq         = 10'h000;
    bus.out_ready       = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_seq", 32'(bus.out_seq), 32'h3FF);
    checkOutput("rst_drop", 32'(bus.drop_empty), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

    // EndSeq non-empty with consumer always ready
    applyStimulus(1'b1, 1'b0, 10'h07F, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b1);
    checkOutput("t1_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t1_seq", 32'(bus.out_seq), 32'h07F);
    checkOutput("t1_count", 32'(bus.count), 32'd1);
    tick();
    checkOutput("t1_drained", 32'(bus.count), 32'd0);
    checkOutput("t1_valid0", 32'(bus.out_valid), 32'd0);

    // Space non-empty: sequence then SPACE word
    applyStimulus(1'b1, 1'b1, 10'h13F, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b0);
    checkOutput("t2_seq", 32'(bus.out_seq), 32'h13F);
    checkOutput("t2_count1", 32'(bus.count), 32'd1);
    checkOutput("t2_pend_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    checkOutput("t2_count2", 32'(bus.count), 32'd2);
    checkOutput("t2_idle_ready", 32'(bus.cmd_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b1);
    tick();
    checkOutput("t2_space", 32'(bus.out_seq), 32'h2FF);
    checkOutput("t2_count_pop", 32'(bus.count), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b0);
    checkOutput("t2_empty", 32'(bus.count), 32'd0);

    // Space empty -> single SPACE; EndSeq empty -> dropped with pulse
    applyStimulus(1'b1, 1'b1, 10'h3FF, 1'b0);
    tick();
    checkOutput("t3_space_cnt", 32'(bus.count), 32'd1);
    checkOutput("t3_space_seq", 32'(bus.out_seq), 32'h2FF);
    checkOutput("t3_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("t3_no_drop", 32'(bus.drop_empty), 32'd0);
    applyStimulus(1'b1, 1'b0, 10'h3FF, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b0);
    checkOutput("t3_drop", 32'(bus.drop_empty), 32'd1);
    checkOutput("t3_drop_cnt", 32'(bus.count), 32'd1);
    tick();
    checkOutput("t3_drop_end", 32'(bus.drop_empty), 32'd0);
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b0);
    checkOutput("t3_empty", 32'(bus.count), 32'd0);

    // Fill to 3, Space non-empty fills to 4 and SPACE stalls until a pop
    drainList[0] = 10'h155;
    drainList[1] = 10'h05F;
    drainList[2] = 10'h0BF;
    drainList[3] = 10'h2FF;
    applyStimulus(1'b1, 1'b0, 10'h000, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 10'h155, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 10'h05F, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 10'h0BF, 1'b0);
    checkOutput("t4_ready3", 32'(bus.cmd_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b0);
    checkOutput("t4_count4", 32'(bus.count), 32'd4);
    checkOutput("t4_full_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    checkOutput("t4_stall_cnt", 32'(bus.count), 32'd4);
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b1);
    checkOutput("t4_pend_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("t4_head", 32'(bus.out_seq), 32'h000);
    tick();
    checkOutput("t4_swap_cnt", 32'(bus.count), 32'd4);
    checkOutput("t4_idle_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t4_order%0d", i), 32'(bus.out_seq), 32'(drainList[i]));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b0);
    checkOutput("t4_empty", 32'(bus.count), 32'd0);
    checkOutput("t4_valid0", 32'(bus.out_valid), 32'd0);

    // Full queue with simultaneous push and pop across pointer wrap
    expq.delete();
    for (int i = 0; i < 4; i++) begin
      val = 10'((i * 37 + 1) & 8'hFF);
      applyStimulus(1'b1, 1'b0, val, 1'b0);
      tick();
      expq.push_back(val);
    end
    for (int i = 4; i < 16; i++) begin
      val = 10'((i * 37 + 1) & 8'hFF);
      applyStimulus(1'b1, 1'b0, val, 1'b1);
      checkOutput($sformatf("t5_head%0d", i), 32'(bus.out_seq), 32'(expq[0]));
      checkOutput($sformatf("t5_ready%0d", i), 32'(bus.cmd_ready), 32'd1);
      checkOutput($sformatf("t5_count%0d", i), 32'(bus.count), 32'd4);
      tick();
      void'(expq.pop_front());
      expq.push_back(val);
    end
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t5_drain%0d", i), 32'(bus.out_seq), 32'(expq[i]));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b0);
    checkOutput("t5_empty", 32'(bus.count), 32'd0);

    // Reset while a SPACE word is pending discards it
    applyStimulus(1'b1, 1'b1, 10'h13F, 1'b0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 10'h000, 1'b0);
    tick();
    checkOutput("t6_count", 32'(bus.count), 32'd0);
    checkOutput("t6_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_seq", 32'(bus.out_seq), 32'h3FF);
    checkOutput("t6_rst_ready", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("t6_no_space", 32'(bus.count), 32'd0);
    checkOutput("t6_valid_late", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_ready_late", 32'(bus.cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
